// File: rtl/uart_echo_buffer.sv
// -----------------------------------------------------------------------------
// uart_echo_buffer
//
// Buffered UART echo engine. Received bytes are acknowledged, optionally
// transformed (upper-casing, CR -> CR LF), queued in a DEPTH-entry FIFO and
// retransmitted through the uart register handshake. The transmit side waits
// for tx_busy to rise and then fall before it moves on to the next byte.
//
// Optional feature macro: ECHO_STATS_EN
//   defined   : rx_count / tx_count / drop_count are live 16-bit wrapping
//               counters, cleared by rst only.
//   undefined : the three counter outputs are tied to zero.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   mode        in   0 raw, 1 upper-case, 2 CR->CR LF, 3 sink
//   flush       in   one-cycle pulse: empty FIFO, clear overflow
//   tx_hold     in   blocks the start of new transmissions
//   rx_data     in   received byte (uart reg_dat_do)
//   rx_valid    in   received byte available
//   rx_ack      out  one-cycle read strobe (uart reg_dat_re)
//   tx_data     out  byte to transmit (uart reg_dat_di)
//   tx_start    out  one-cycle write strobe (uart reg_dat_we)
//   tx_busy     in   uart transmitter busy
//   level       out  FIFO occupancy
//   overflow    out  sticky: a byte was dropped on a full FIFO
//   rx_count    out  accepted byte count
//   tx_count    out  tx_start count (LF included)
//   drop_count  out  full-drop count
// -----------------------------------------------------------------------------
module uart_echo_buffer #(
    parameter int DEPTH = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             flush,
    input  logic             tx_hold,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ack,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_busy,
    output logic [LVL_W-1:0] level,
    output logic             overflow,
    output logic [15:0]      rx_count,
    output logic [15:0]      tx_count,
    output logic [15:0]      drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_WAIT_HI = 3'd2;
    localparam logic [2:0] ST_WAIT_LO = 3'd3;
    localparam logic [2:0] ST_LF      = 3'd4;

    // Builds the 9-bit FIFO entry {lf, data} using the mode seen at accept,
    // so later mode changes never alter bytes already queued.
    function automatic logic [8:0] encode_entry(input logic [7:0] byte_in,
                                                input logic [1:0] mode_in);
        logic [8:0] entry;
        entry = {1'b0, byte_in};
        case (mode_in)
            2'd1: begin
                if ((byte_in >= 8'h61) && (byte_in <= 8'h7A)) begin
                    entry = {1'b0, byte_in - 8'h20};
                end else begin
                    entry = {1'b0, byte_in};
                end
            end
            2'd2:    entry = {(byte_in == 8'h0D), byte_in};
            default: entry = {1'b0, byte_in};
        endcase
        return entry;
    endfunction

    logic             rx_ack_r;
    logic [7:0]       tx_data_r;
    logic             tx_start_r;
    logic             lf_pend_r;
    logic [2:0]       state_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             overflow_r;
    logic [8:0]       mem_r [DEPTH];

    logic             accept_s;
    logic             push_req_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             drop_s;
    logic             pop_s;
    logic [8:0]       push_entry_s;
    logic [8:0]       rd_entry_s;

    // A byte is taken while rx_ack is low; the ack itself masks the
    // still-high rx_valid in the following cycle.
    assign accept_s     = rx_valid && !rx_ack_r;
    assign push_req_s   = accept_s && (mode != 2'd3);
    assign full_s       = (level_r == FULL_LVL);
    assign empty_s      = (level_r == {LVL_W{1'b0}});
    // flush takes priority: a colliding byte is neither stored nor a drop.
    // A pop never frees room for a push in the same cycle.
    assign push_s       = push_req_s && !full_s && !flush;
    assign drop_s       = push_req_s && full_s && !flush;
    assign pop_s        = (state_r == ST_IDLE) && !empty_s && !tx_hold
                          && !tx_busy && !flush;
    assign push_entry_s = encode_entry(rx_data, mode);
    assign rd_entry_s   = mem_r[rd_ptr_r];

    // FIFO storage; unwritten entries are never read because pops need level>0.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // Read acknowledge: registered one-cycle pulse per accepted byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ack_r <= 1'b0;
        end else begin
            rx_ack_r <= accept_s;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky overflow flag, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    // Transmit FSM. tx_start is registered on leaving START, so tx_data is
    // already stable when the strobe appears. The LF state ignores tx_hold
    // so a CR LF pair is never split.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            lf_pend_r  <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        tx_data_r <= rd_entry_s[7:0];
                        lf_pend_r <= rd_entry_s[8];
                        state_r   <= ST_START;
                    end
                end
                ST_START: begin
                    tx_start_r <= 1'b1;
                    state_r    <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (tx_busy) begin
                        state_r <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        state_r <= lf_pend_r ? ST_LF : ST_IDLE;
                    end
                end
                ST_LF: begin
                    tx_data_r <= 8'h0A;
                    lf_pend_r <= 1'b0;
                    state_r   <= ST_START;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ECHO_STATS_EN
    logic [15:0] rx_count_r;
    logic [15:0] tx_count_r;
    logic [15:0] drop_count_r;

    // Statistics counters; wrap at 16 bits, flush does not touch them.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count_r   <= 16'd0;
            tx_count_r   <= 16'd0;
            drop_count_r <= 16'd0;
        end else begin
            if (accept_s) begin
                rx_count_r <= rx_count_r + 16'd1;
            end
            // Leaving START is exactly the edge that raises tx_start.
            if (state_r == ST_START) begin
                tx_count_r <= tx_count_r + 16'd1;
            end
            if (drop_s) begin
                drop_count_r <= drop_count_r + 16'd1;
            end
        end
    end

    assign rx_count   = rx_count_r;
    assign tx_count   = tx_count_r;
    assign drop_count = drop_count_r;
`else
    assign rx_count   = 16'd0;
    assign tx_count   = 16'd0;
    assign drop_count = 16'd0;
`endif

    assign rx_ack   = rx_ack_r;
    assign tx_data  = tx_data_r;
    assign tx_start = tx_start_r;
    assign level    = level_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_echo_buffer
//
// Directed self-checking bench for uart_echo_buffer (DEPTH=16). A small uart
// transmitter model raises tx_busy one cycle after each tx_start, holds it for
// four cycles, and logs every transmitted byte. Counter expectations follow
// ECHO_STATS_EN: live values when defined, zero otherwise.
// -----------------------------------------------------------------------------
module tb_uart_echo_buffer;

    localparam int DEPTH = 16;
    localparam int LVL_W = 5;
`ifdef ECHO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             flush;
    logic             tx_hold;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ack;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_busy = 1'b0;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic [15:0]      rx_count;
    logic [15:0]      tx_count;
    logic [15:0]      drop_count;

    int n_pass  = 0;
    int n_total = 0;

    uart_echo_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .flush      (flush),
        .tx_hold    (tx_hold),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .level      (level),
        .overflow   (overflow),
        .rx_count   (rx_count),
        .tx_count   (tx_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // uart transmitter model plus strobe monitors
    int         busy_cnt   = 0;
    int         ack_cnt    = 0;
    int         start_cnt  = 0;
    int         glitch_cnt = 0;
    logic [7:0] cur_byte   = 8'h00;
    logic [7:0] tx_log[$];

    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
            tx_busy  <= 1'b0;
        end else if (tx_start && busy_cnt == 0) begin
            busy_cnt <= 4;
            tx_busy  <= 1'b1;
            cur_byte <= tx_data;
            tx_log.push_back(tx_data);
        end else if (busy_cnt > 0) begin
            if (tx_data !== cur_byte) glitch_cnt <= glitch_cnt + 1;
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) tx_busy <= 1'b0;
        end
        if (rx_ack === 1'b1) ack_cnt <= ack_cnt + 1;
        if (tx_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    int base;
    int acks0;
    int starts0;

    initial begin
        rst      = 1'b1;
        mode     = 2'd0;
        flush    = 1'b0;
        tx_hold  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // reset values
        check("rst_rx_ack", rx_ack, 1'b0);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_level", level, 5'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_rx_count", rx_count, 16'd0);
        check("rst_tx_count", tx_count, 16'd0);
        check("rst_drop_count", drop_count, 16'd0);
        tick();

        // mode 0, single byte latency
        base  = tx_log.size();
        acks0 = ack_cnt;
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        tick();
        rx_valid = 1'b0;
        check("t1_ack_n1", rx_ack, 1'b1);
        check("t1_level_n1", level, 5'd1);
        check("t1_start_n1", tx_start, 1'b0);
        tick();
        check("t1_ack_n2", rx_ack, 1'b0);
        check("t1_level_n2", level, 5'd0);
        check("t1_start_n2", tx_start, 1'b0);
        tick();
        check("t1_start_n3", tx_start, 1'b1);
        check("t1_data_n3", tx_data, 8'h41);
        tick();
        check("t1_start_n4", tx_start, 1'b0);
        repeat (20) tick();
        check("t1_log_size", tx_log.size() - base, 1);
        check("t1_log_byte", tx_log[base], 8'h41);
        check("t1_ack_pulses", ack_cnt - acks0, 1);

        // mode 1, upper-casing
        mode = 2'd1;
        base = tx_log.size();
        send_byte(8'h61);
        send_byte(8'h5A);
        send_byte(8'h7B);
        repeat (60) tick();
        check("t2_log_size", tx_log.size() - base, 3);
        check("t2_byte0", tx_log[base], 8'h41);
        check("t2_byte1", tx_log[base + 1], 8'h5A);
        check("t2_byte2", tx_log[base + 2], 8'h7B);

        // mode 2, CR LF; mode switch after the CR is queued
        mode = 2'd2;
        base = tx_log.size();
        send_byte(8'h0D);
        mode = 2'd0;
        send_byte(8'h31);
        repeat (60) tick();
        check("t3_log_size", tx_log.size() - base, 3);
        check("t3_byte0", tx_log[base], 8'h0D);
        check("t3_byte1", tx_log[base + 1], 8'h0A);
        check("t3_byte2", tx_log[base + 2], 8'h31);

        // overflow with tx_hold, then drain
        mode    = 2'd0;
        tx_hold = 1'b1;
        base    = tx_log.size();
        starts0 = start_cnt;
        for (int i = 0; i < 18; i++) send_byte(8'h20 + 8'(i));
        check("t4_level_full", level, 5'd16);
        check("t4_overflow", overflow, 1'b1);
        check("t4_drop_count", drop_count, STATS ? 16'd2 : 16'd0);
        check("t4_held_starts", start_cnt - starts0, 0);
        tx_hold = 1'b0;
        repeat (300) tick();
        check("t4_log_size", tx_log.size() - base, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t4_byte%0d", i), tx_log[base + i], 8'h20 + 8'(i));
        end
        check("t4_level_empty", level, 5'd0);
        check("t4_overflow_sticky", overflow, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_flush_clears_ovf", overflow, 1'b0);

        // mode 3 sink
        mode    = 2'd3;
        acks0   = ack_cnt;
        starts0 = start_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i));
        repeat (20) tick();
        check("t5_ack_pulses", ack_cnt - acks0, 5);
        check("t5_no_start", start_cnt - starts0, 0);
        check("t5_level", level, 5'd0);
        check("t5_rx_count", rx_count, STATS ? 16'd29 : 16'd0);
        check("t5_tx_count", tx_count, STATS ? 16'd23 : 16'd0);

        // flush colliding with a push, one byte in flight
        mode = 2'd0;
        base = tx_log.size();
        send_byte(8'h55);
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        check("t6_level_pre", level, 5'd3);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        flush    = 1'b1;
        tick();
        rx_valid = 1'b0;
        flush    = 1'b0;
        check("t6_flush_ack", rx_ack, 1'b1);
        check("t6_level_post", level, 5'd0);
        check("t6_overflow", overflow, 1'b0);
        repeat (40) tick();
        check("t6_log_size", tx_log.size() - base, 1);
        check("t6_inflight_byte", tx_log[base], 8'h55);
        check("t6_level_end", level, 5'd0);
        check("t6_drop_count", drop_count, STATS ? 16'd2 : 16'd0);
        check("t6_rx_count", rx_count, STATS ? 16'd34 : 16'd0);
        check("t6_tx_count", tx_count, STATS ? 16'd24 : 16'd0);
        check("tx_data_stable", glitch_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
